// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data-side memory subsystem: MMIO register offsets,
// console status bit positions and the default I/O window base.
package data_mem_mmio_pkg;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h8000_0000;

    localparam logic [7:0] OFF_CON_TX   = 8'h00;
    localparam logic [7:0] OFF_CON_STAT = 8'h04;
    localparam logic [7:0] OFF_CYC_LO   = 8'h08;
    localparam logic [7:0] OFF_CYC_HI   = 8'h0C;
    localparam logic [7:0] OFF_HALT     = 8'h10;

    localparam int STAT_COUNT_LSB    = 0;
    localparam int STAT_FULL_BIT     = 4;
    localparam int STAT_OVERFLOW_BIT = 8;

    typedef enum logic [2:0] {
        IO_CON_TX,
        IO_CON_STAT,
        IO_CYC_LO,
        IO_CYC_HI,
        IO_HALT,
        IO_NONE
    } io_reg_e;

    // Word-aligned offset to register select; unmapped offsets fall to IO_NONE.
    function automatic io_reg_e decode_offset(input logic [7:0] offset);
        case (offset)
            OFF_CON_TX:   return IO_CON_TX;
            OFF_CON_STAT: return IO_CON_STAT;
            OFF_CYC_LO:   return IO_CYC_LO;
            OFF_CYC_HI:   return IO_CYC_HI;
            OFF_HALT:     return IO_HALT;
            default:      return IO_NONE;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_mmio_console_fifo.sv
// Byte-wide synchronous console FIFO; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate occupancy counter.
module console_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               data,
    input  logic                     pop,
    output logic                     valid,
    output logic [7:0]               head,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data;
    end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory: byte-enabled word RAM plus an MMIO window holding the
// console FIFO, a 64-bit cycle counter with high-word snapshot and a halt latch.
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_data_out,
    output logic [31:0] dmem_data_in,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_byte_enable,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        halt,
    output logic [31:0] halt_code
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      ram [MEM_WORDS];
    logic [IDX_W-1:0] ram_idx;
    logic             is_io;
    io_reg_e          io_reg;

    logic [63:0]      cyc_count;
    logic [31:0]      cyc_shadow;
    logic             overflow;

    logic             con_push;
    logic             con_full;
    logic [CNT_W-1:0] fifo_count;
    logic [3:0]       count_disp;
    logic [31:0]      stat_word;
    logic             halt_write;
    logic             unused_addr_bits;

    assign is_io            = (dmem_addr[31:8] == MMIO_BASE[31:8]);
    assign io_reg           = decode_offset({dmem_addr[7:2], 2'b00});
    assign ram_idx          = dmem_addr[IDX_W+1:2];
    assign unused_addr_bits = ^dmem_addr[1:0];

    // I/O stores that coincide with reset are discarded; RAM stores are not.
    assign con_push   = dmem_write && is_io && !reset && (io_reg == IO_CON_TX) && dmem_byte_enable[0];
    assign halt_write = dmem_write && is_io && (io_reg == IO_HALT) && (|dmem_byte_enable);

    console_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (con_push),
        .data  (dmem_data_out[7:0]),
        .pop   (con_ready),
        .valid (con_valid),
        .head  (con_data),
        .full  (con_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (dmem_write && !is_io) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (dmem_byte_enable[lane]) begin
                    ram[ram_idx][8*lane +: 8] <= dmem_data_out[8*lane +: 8];
                end
            end
        end
    end

    always_comb begin
        count_disp = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
        stat_word  = '0;
        stat_word[STAT_COUNT_LSB +: 4]  = count_disp;
        stat_word[STAT_FULL_BIT]        = con_full;
        stat_word[STAT_OVERFLOW_BIT]    = overflow;
    end

    always_comb begin
        dmem_data_in = '0;
        if (dmem_read) begin
            if (!is_io) begin
                dmem_data_in = ram[ram_idx];
            end else begin
                case (io_reg)
                    IO_CON_STAT: dmem_data_in = stat_word;
                    IO_CYC_LO:   dmem_data_in = cyc_count[31:0];
                    IO_CYC_HI:   dmem_data_in = cyc_shadow;
                    default:     dmem_data_in = '0;
                endcase
            end
        end
    end

    // The shadow captures the pre-increment high word so LO then HI reads are coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_count  <= '0;
            cyc_shadow <= '0;
            overflow   <= 1'b0;
            halt       <= 1'b0;
            halt_code  <= '0;
        end else begin
            if (!halt) cyc_count <= cyc_count + 64'd1;
            if (dmem_read && is_io && (io_reg == IO_CYC_LO)) cyc_shadow <= cyc_count[63:32];
            if (con_push && con_full && !(con_valid && con_ready)) overflow <= 1'b1;
            if (halt_write && !halt) begin
                halt      <= 1'b1;
                halt_code <= dmem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed vector table, hand-written
// corner sequences and randomized traffic compared against a queue-based model.
`timescale 1ns/1ps
module tb_data_mem_mmio;

    localparam int          MEM_WORDS  = 1024;
    localparam int          FIFO_DEPTH = 8;
    localparam int          IW         = $clog2(MEM_WORDS);
    localparam logic [31:0] BASE       = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data_out;
    logic [31:0] dmem_data_in;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_byte_enable;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        halt;
    logic [31:0] halt_code;

    always #5 clk = ~clk;

    data_mem_mmio #(
        .MEM_WORDS  (MEM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MMIO_BASE  (BASE)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .dmem_addr        (dmem_addr),
        .dmem_data_out    (dmem_data_out),
        .dmem_data_in     (dmem_data_in),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .con_valid        (con_valid),
        .con_data         (con_data),
        .con_ready        (con_ready),
        .halt             (halt),
        .halt_code        (halt_code)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        ready;
        logic        rst;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        logic        chk_con;
        logic        exp_valid;
        logic [7:0]  exp_head;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model state: plain arrays, a byte queue and a 64-bit integer counter.
    logic [31:0] m_ram   [MEM_WORDS];
    bit          m_known [MEM_WORDS];
    logic [7:0]  m_fifo  [$];
    logic [63:0] m_cyc;
    logic [31:0] m_shadow;
    bit          m_ovf;
    bit          m_halt;
    logic [31:0] m_code;
    bit          m_live = 0;

    vec_t vectors [$];

    function automatic vec_t mk(bit rd, bit wr, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] be, bit ready);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.ready = ready;
        v.rst = 1'b0; v.chk_rdata = 1'b0; v.exp_rdata = '0;
        v.chk_con = 1'b0; v.exp_valid = 1'b0; v.exp_head = '0;
        return v;
    endfunction

    function automatic vec_t idle(bit ready);
        return mk(0, 0, 32'h0, 32'h0, 4'h0, ready);
    endfunction

    function automatic vec_t expR(vec_t v, logic [31:0] value);
        vec_t r = v;
        r.chk_rdata = 1'b1;
        r.exp_rdata = value;
        return r;
    endfunction

    function automatic vec_t expC(vec_t v, bit valid, logic [7:0] head);
        vec_t r = v;
        r.chk_con   = 1'b1;
        r.exp_valid = valid;
        r.exp_head  = head;
        return r;
    endfunction

    function automatic bit isIo(logic [31:0] addr);
        return addr[31:8] == BASE[31:8];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic modelRead(input vec_t v, output logic [31:0] d, output bit known);
        int n;
        d = '0;
        known = 1'b1;
        if (v.rd) begin
            if (!isIo(v.addr)) begin
                d     = m_ram[v.addr[IW+1:2]];
                known = m_known[v.addr[IW+1:2]];
            end else begin
                case ({v.addr[7:2], 2'b00})
                    8'h04: begin
                        n = m_fifo.size();
                        d = {23'b0, m_ovf, 3'b0, (n == FIFO_DEPTH), (n > 15) ? 4'hF : 4'(n)};
                    end
                    8'h08:   d = m_cyc[31:0];
                    8'h0C:   d = m_shadow;
                    default: d = '0;
                endcase
            end
        end
    endtask

    task automatic modelUpdate(input vec_t v);
        logic [63:0] old_cyc  = m_cyc;
        bit          old_halt = m_halt;
        logic [7:0]  off      = {v.addr[7:2], 2'b00};
        bool_io: begin end
        if (v.wr && !isIo(v.addr)) begin
            for (int b = 0; b < 4; b++)
                if (v.be[b]) m_ram[v.addr[IW+1:2]][8*b +: 8] = v.wdata[8*b +: 8];
            if (v.be == 4'hF) m_known[v.addr[IW+1:2]] = 1'b1;
        end
        if (v.rst) begin
            m_fifo.delete();
            m_cyc = '0; m_shadow = '0; m_ovf = 0; m_halt = 0; m_code = '0;
            m_live = 1;
        end else begin
            if (!old_halt) m_cyc = old_cyc + 64'd1;
            if (v.rd && isIo(v.addr) && off == 8'h08) m_shadow = old_cyc[63:32];
            if (m_fifo.size() > 0 && v.ready) void'(m_fifo.pop_front());
            if (v.wr && isIo(v.addr) && off == 8'h00 && v.be[0]) begin
                if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(v.wdata[7:0]);
                else m_ovf = 1;
            end
            if (v.wr && isIo(v.addr) && off == 8'h10 && v.be != 0 && !old_halt) begin
                m_halt = 1;
                m_code = v.wdata;
            end
        end
    endtask

    // Called at a falling edge: drive, sample mid-cycle, let the rising edge pass, update the model.
    task automatic applyStimulus(input vec_t v, input string tag);
        logic [31:0] d;
        bit          known;
        reset            = v.rst;
        dmem_read        = v.rd;
        dmem_write       = v.wr;
        dmem_addr        = v.addr;
        dmem_data_out    = v.wdata;
        dmem_byte_enable = v.be;
        con_ready        = v.ready;
        #2;
        if (m_live) begin
            modelRead(v, d, known);
            if (known) checkOutput({tag, " rdata/model"}, dmem_data_in, d);
            checkOutput({tag, " con_valid/model"}, 32'(con_valid), 32'(m_fifo.size() != 0));
            checkOutput({tag, " con_data/model"}, 32'(con_data),
                        (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'h0);
            checkOutput({tag, " halt/model"}, 32'(halt), 32'(m_halt));
            checkOutput({tag, " halt_code/model"}, halt_code, m_code);
        end
        if (v.chk_rdata) checkOutput({tag, " rdata"}, dmem_data_in, v.exp_rdata);
        if (v.chk_con) begin
            checkOutput({tag, " con_valid"}, 32'(con_valid), 32'(v.exp_valid));
            checkOutput({tag, " con_data"}, 32'(con_data), 32'(v.exp_head));
        end
        @(posedge clk);
        #1;
        modelUpdate(v);
        @(negedge clk);
    endtask

    function automatic vec_t randomVec();
        vec_t v = idle($urandom_range(0, 1));
        int kind = $urandom_range(0, 9);
        logic [31:0] word;
        logic [31:0] alias_sel;
        case (kind)
            0, 1, 2, 3: begin
                word      = $urandom_range(0, 15);
                alias_sel = $urandom_range(0, 7);
                v = mk($urandom_range(0, 1), $urandom_range(0, 1),
                       (alias_sel << 12) | (word << 2) | 32'($urandom_range(0, 3)),
                       $urandom, 4'($urandom), v.ready);
            end
            4, 5: v = mk($urandom_range(0, 1), 1, BASE | 32'h00, $urandom, 4'($urandom), v.ready);
            6, 7: begin
                word = 32'h04 + 32'($urandom_range(0, 2)) * 4;
                v = mk(1, $urandom_range(0, 3) == 0, BASE | word, $urandom, 4'hF, v.ready);
            end
            8: v = mk($urandom_range(0, 1), $urandom_range(0, 1),
                      BASE | (32'($urandom_range(5, 63)) << 2), $urandom, 4'hF, v.ready);
            default: if ($urandom_range(0, 9) == 0)
                         v = mk(0, 1, BASE | 32'h10, $urandom, 4'($urandom_range(1, 15)), v.ready);
        endcase
        if ($urandom_range(0, 63) == 0) v.rst = 1'b1;
        return v;
    endfunction

    initial begin
        vec_t v;
        localparam logic [31:0] TX   = BASE | 32'h00;
        localparam logic [31:0] STAT = BASE | 32'h04;
        localparam logic [31:0] CLO  = BASE | 32'h08;
        localparam logic [31:0] CHI  = BASE | 32'h0C;
        localparam logic [31:0] HLT  = BASE | 32'h10;

        // Directed vectors: RAM lanes, aliasing, console flow, overflow and full push+pop.
        vectors.push_back(mk(0, 1, 32'h40, 32'hAABB_CCDD, 4'hF, 0));
        vectors.push_back(mk(0, 1, 32'h40, 32'h1122_3344, 4'h5, 0));
        vectors.push_back(expR(mk(1, 0, 32'h40, 0, 0, 0), 32'hAA22_CC44));
        vectors.push_back(expR(mk(1, 0, 32'h40 + 4 * MEM_WORDS, 0, 0, 0), 32'hAA22_CC44));
        vectors.push_back(expR(mk(1, 0, BASE | 32'h14, 0, 0, 0), 32'h0));
        vectors.push_back(expC(mk(0, 1, TX, 32'h48, 4'h1, 0), 0, 8'h00));
        vectors.push_back(expC(mk(0, 1, TX, 32'h69, 4'h1, 0), 1, 8'h48));
        vectors.push_back(expC(expR(mk(1, 0, STAT, 0, 0, 0), 32'h2), 1, 8'h48));
        vectors.push_back(expC(idle(1), 1, 8'h48));
        vectors.push_back(expC(idle(1), 1, 8'h69));
        vectors.push_back(expC(idle(0), 0, 8'h00));
        for (int i = 0; i < FIFO_DEPTH; i++)
            vectors.push_back(expC(mk(0, 1, TX, 32'h30 + i, 4'h1, 0), i > 0, (i > 0) ? 8'h30 : 8'h00));
        vectors.push_back(expC(expR(mk(1, 0, STAT, 0, 0, 0), 32'h18), 1, 8'h30));
        vectors.push_back(expC(mk(0, 1, TX, 32'h40, 4'h1, 1), 1, 8'h30));
        vectors.push_back(expC(expR(mk(1, 0, STAT, 0, 0, 0), 32'h18), 1, 8'h31));
        vectors.push_back(expC(mk(0, 1, TX, 32'h41, 4'h1, 0), 1, 8'h31));
        vectors.push_back(expC(expR(mk(1, 0, STAT, 0, 0, 0), 32'h118), 1, 8'h31));
        for (int j = 0; j < FIFO_DEPTH; j++)
            vectors.push_back(expC(idle(1), 1, (j < FIFO_DEPTH - 1) ? 8'(8'h31 + j) : 8'h40));
        vectors.push_back(expC(expR(mk(1, 0, STAT, 0, 0, 0), 32'h100), 0, 8'h00));

        @(negedge clk);
        v = idle(0);
        v.rst = 1'b1;
        applyStimulus(v, "reset0");
        applyStimulus(v, "reset1");
        for (int w = 0; w <= 16; w++) applyStimulus(mk(0, 1, w << 2, $urandom, 4'hF, 0), "init");

        for (int i = 0; i < vectors.size(); i++) applyStimulus(vectors[i], $sformatf("vec%0d", i));

        // Counter carry: preload just below a 32-bit wrap and check the snapshot coherency.
        force dut.cyc_count = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.cyc_count;
        m_cyc = 64'h0000_0000_FFFF_FFFE;
        applyStimulus(idle(0), "wrap idle");
        applyStimulus(expR(mk(1, 0, CLO, 0, 0, 0), 32'hFFFF_FFFF), "wrap lo");
        applyStimulus(expR(mk(1, 0, CHI, 0, 0, 0), 32'h0), "wrap hi");
        applyStimulus(expR(mk(1, 0, CLO, 0, 0, 0), 32'h1), "post lo");
        applyStimulus(expR(mk(1, 0, CHI, 0, 0, 0), 32'h1), "post hi");

        for (int i = 0; i < 600; i++) applyStimulus(randomVec(), $sformatf("rnd%0d", i));

        // Halt: first code wins and the counter freezes.
        v = idle(0);
        v.rst = 1'b1;
        applyStimulus(v, "halt rst");
        applyStimulus(idle(0), "halt c0");
        applyStimulus(mk(0, 1, HLT, 32'h1, 4'hF, 0), "halt w1");
        checkOutput("halt set", 32'(halt), 32'h1);
        checkOutput("halt code", halt_code, 32'h1);
        applyStimulus(mk(0, 1, HLT, 32'h5, 4'hF, 0), "halt w5");
        checkOutput("halt code kept", halt_code, 32'h1);
        applyStimulus(expR(mk(1, 0, CLO, 0, 0, 0), 32'h2), "frozen a");
        applyStimulus(idle(0), "frozen i0");
        applyStimulus(idle(0), "frozen i1");
        applyStimulus(expR(mk(1, 0, CLO, 0, 0, 0), 32'h2), "frozen b");

        // Reset mid-operation with bytes queued and halt set; an I/O store during reset is dropped.
        applyStimulus(mk(0, 1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0), "ram keep");
        applyStimulus(mk(0, 1, TX, 32'h61, 4'h1, 0), "q a");
        applyStimulus(mk(0, 1, TX, 32'h62, 4'h1, 0), "q b");
        applyStimulus(mk(0, 1, TX, 32'h63, 4'h1, 0), "q c");
        applyStimulus(expC(expR(mk(1, 0, STAT, 0, 0, 0), 32'h3), 1, 8'h61), "q stat");
        v = mk(0, 1, HLT, 32'h7, 4'hF, 0);
        v.rst = 1'b1;
        applyStimulus(v, "mid rst");
        checkOutput("rst halt", 32'(halt), 32'h0);
        checkOutput("rst halt_code", halt_code, 32'h0);
        applyStimulus(expC(expR(mk(1, 0, CLO, 0, 0, 0), 32'h0), 0, 8'h00), "rst cyc0");
        applyStimulus(expR(mk(1, 0, 32'h100, 0, 0, 0), 32'hDEAD_BEEF), "rst ram");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory subsystem attached directly to the `rv32e_cpu` data port; it consumes the CPU's `dmem_*` requests. It provides a byte-enabled word RAM plus a small memory-mapped I/O window. The window holds a console transmit FIFO, a 64-bit cycle counter with coherent high-word snapshot, and a sticky halt register used by simulation and test harnesses. Reads are combinational so the CPU's MEM stage captures data in the same cycle; all state changes occur on the rising edge.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: console FIFO entries; power of two, ≥2.
- `MMIO_BASE`, 32'h8000_0000: base address of the I/O window; aligned to 256 bytes.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `dmem_addr` in 32: byte address from CPU; bits [1:0] ignored.
- `dmem_data_out` in 32: store data from CPU, lane-aligned.
- `dmem_data_in` out 32: load data to CPU, full word.
- `dmem_read` in 1: load request, this cycle.
- `dmem_write` in 1: store request, this cycle.
- `dmem_byte_enable` in 4: lane strobes; bit i covers bits [8i+7:8i].
- `con_valid` out 1: console byte available.
- `con_data` out 8: console byte at FIFO head.
- `con_ready` in 1: consumer accepts head this cycle.
- `halt` out 1: sticky halt flag.
- `halt_code` out 32: value written to HALT.

## Operation
- Decode: `dmem_addr[31:8] == MMIO_BASE[31:8]` → I/O; otherwise RAM. RAM index = `dmem_addr[log2(MEM_WORDS)+1:2]`; upper bits ignored (aliases, wraps modulo MEM_WORDS).
- RAM store: each lane with strobe set is written at the edge; other lanes are unchanged. RAM contents are not reset.
- I/O offsets (`dmem_addr[7:0]`):
  - 0x00 CON_TX: write with be[0] pushes `dmem_data_out[7:0]`. Reads return 0.
  - 0x04 CON_STAT: read-only `{23'b0, overflow, 3'b0, full, count[3:0]}`; count saturates at 15 for display.
  - 0x08 CYC_LO: read returns live counter[31:0]. The same access latches counter[63:32] into the shadow register at the edge.
  - 0x0C CYC_HI: read returns the shadow.
  - 0x10 HALT: any write with be≠0 sets `halt`=1 and `halt_code`=`dmem_data_out`. Ignored while `halt` is already 1, so the first code wins.
  - Other offsets: read 0, writes ignored; never an error.
- `dmem_data_in` = 0 when `dmem_read`=0.
- FIFO push when full: the byte is dropped and `overflow` is set; it is sticky until reset. Push and pop in the same cycle while full: pop frees an entry and the push is accepted, no overflow. Push and pop while empty: `con_valid` was 0, so the push is simply stored.
- `con_valid` = not empty; `con_data` = head entry, stable while `con_valid`&&!`con_ready`.
- Cycle counter: 64-bit, +1 every edge after reset, wraps to 0. It freezes once `halt`=1.
- `dmem_read` and `dmem_write` both high: the store commits at the edge, and the read returns the pre-edge value.

## Timing
- Load latency 0: `dmem_data_in` is a combinational function of the address and current state.
- Store/push/halt take effect at the rising edge of the request cycle and are visible to a read in the next cycle.
- Pushed byte: `con_valid` rises the cycle after the push edge.
- Pop: occurs at an edge with `con_valid`&&`con_ready`.
- CON_STAT reads reflect pre-edge state.
- CYC_LO read in cycle N returns the value N cycles after reset release. Counter value 0 appears in the first cycle with `reset` low.
- Reset (any cycle, including mid-transfer):
  - FIFO emptied, `con_valid`=0, `con_data`=0.
  - counter=0, shadow=0, `overflow`=0, `halt`=0, `halt_code`=0.
  - A store coincident with reset to RAM is performed; to I/O it is discarded.

## Structure
- Shared package constants: MMIO offsets (CON_TX, CON_STAT, CYC_LO, CYC_HI, HALT), CON_STAT bit positions, default MMIO_BASE.
- One sub-module: `console_fifo` (synchronous FIFO, width 8, depth FIFO_DEPTH).
  - Ports: push/data, pop, valid/head, full, count.
  - Pointers one bit wider than the index for full/empty detection.
- Decode, RAM, counter and halt logic live in `data_mem_mmio`.

## Test plan
- RAM byte lanes: write 0xAABBCCDD be=1111 to 0x40, then 0x11223344 be=0101 to 0x40 → read 0x40 = 0xAA22CC44. Read 0x40+4·MEM_WORDS returns the same value (alias).
- Console flow:
  - Push 'H','i' with `con_ready`=0 → CON_STAT count=2, head 0x48.
  - Raise `con_ready` → 0x48 then 0x69 over two cycles, `con_valid` falls after.
- Overflow: push FIFO_DEPTH+1 bytes with `con_ready`=0 → full=1, overflow=1, last byte absent. Push+pop in the same cycle while full → count unchanged, overflow not newly set.
- Cycle snapshot: force counter to 0x0000_0000_FFFF_FFFF via run or preload. Read CYC_LO at wrap → shadow holds the pre-carry high word, and CYC_HI returns it consistently.
- Halt: write 0x0000_0001 to HALT → `halt`=1, code=1. Second write of 0x5 → code stays 1. Counter stops incrementing.
- Reset mid-operation: with 3 bytes queued and `halt`=1, pulse `reset` → `con_valid`=0, `halt`=0, CYC_LO reads 0 in the first cycle after release, and RAM contents are retained.
